// File: rtl/duty_ramp_ctrl_if.sv
// duty_ramp_ctrl_if: target-offer handshake between a duty-setpoint source
// (master) and duty_ramp_ctrl (slave).
//
// Handshake: the master drives tgt_valid and tgt_duty; the slave drives
// tgt_ready. A target transfers on every rising clk edge where
// tgt_valid && tgt_ready are both 1. The master may hold tgt_valid high for
// as long as it wants; while tgt_ready is 0 the offer is not taken and
// tgt_duty may change freely without effect.
`timescale 1ns/1ps

interface duty_ramp_ctrl_if;
    logic       tgt_valid;
    logic [7:0] tgt_duty;
    logic       tgt_ready;

    modport master (
        output tgt_valid,
        output tgt_duty,
        input  tgt_ready
    );

    modport slave (
        input  tgt_valid,
        input  tgt_duty,
        output tgt_ready
    );
endinterface

// File: rtl/duty_ramp_ctrl.sv
// duty_ramp_ctrl: moves an 8-bit PWM duty toward a requested target by STEP
// once per PWM period (tick), so the downstream PWM never jumps abruptly.
//
// Optional build macro DUTY_RAMP_HOLD_EN adds a 'hold' input that freezes the
// ramp (ticks ignored in RAMP) while the tick counter keeps running.
//
// States: IDLE (accepting targets) and RAMP (stepping on ticks). dbg_state
// exposes the state register (0 = IDLE, 1 = RAMP).
`timescale 1ns/1ps

module duty_ramp_ctrl #(
    parameter int PERIOD_CLKS = 500_000,
    parameter int STEP        = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    duty_ramp_ctrl_if.slave        tgt,
`ifdef DUTY_RAMP_HOLD_EN
    input  logic                   hold,
`endif
    output logic [7:0]             duty_cycle,
    output logic                   busy,
    output logic                   done,
    output logic                   dbg_state
);

    localparam int               CNT_W   = (PERIOD_CLKS > 1) ? $clog2(PERIOD_CLKS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIOD_CLKS - 1);
    localparam logic [8:0]       STEP_9  = 9'(STEP);
    localparam logic [7:0]       STEP_8  = 8'(STEP);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RAMP = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic             step_en;
    logic             ready_int;
    logic             accept;
    logic [7:0]       target;
    logic [8:0]       diff_raw;
    logic [8:0]       diff_abs;
    logic             going_up;
    logic             last_step;

    // Free-running period counter; never disturbed by target traffic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CNT_MAX);

`ifdef DUTY_RAMP_HOLD_EN
    assign step_en = tick & ~hold;
`else
    assign step_en = tick;
`endif

    assign accept = tgt.tgt_valid & ready_int;

    // Distance to target in 9 bits so 0-255 and 255-0 both stay representable.
    always_comb begin
        diff_raw  = {1'b0, target} - {1'b0, duty_cycle};
        going_up  = ~diff_raw[8];
        diff_abs  = diff_raw[8] ? (9'd0 - diff_raw) : diff_raw;
        last_step = (diff_abs <= STEP_9);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: start a ramp on a non-trivial target, leave on the final step.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept && (tgt.tgt_duty != duty_cycle)) begin
                    state_nxt = S_RAMP;
                end
            end
            S_RAMP: begin
                if (step_en && last_step) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Moore outputs decoded straight from the state register.
    always_comb begin
        ready_int = (state == S_IDLE);
        busy      = (state == S_RAMP);
        dbg_state = (state == S_RAMP);
    end

    assign tgt.tgt_ready = ready_int;

    // Target latch, duty stepping with clamp to target, and the done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            target     <= 8'd0;
            duty_cycle <= 8'd0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if ((state == S_IDLE) && accept) begin
                target <= tgt.tgt_duty;
                if (tgt.tgt_duty == duty_cycle) begin
                    done <= 1'b1;
                end
            end else if ((state == S_RAMP) && step_en) begin
                if (last_step) begin
                    duty_cycle <= target;
                    done       <= 1'b1;
                end else if (going_up) begin
                    duty_cycle <= duty_cycle + STEP_8;
                end else begin
                    duty_cycle <= duty_cycle - STEP_8;
                end
            end
        end
    end

endmodule
